serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder used by the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and carry 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] bload;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cload;
  logic             fs;
  logic             fc;
  logic             accept;
  logic             last;

`ifdef SERIAL_ADDER_SUB_EN
  assign bload = sub ? ~b : b;
  assign cload = sub | cin;
`else
  assign bload = b;
  assign cload = cin;
`endif

  full_adder_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (fs),
    .cout (fc)
  );

  // New sum bit enters at the MSB so bit 0 lands in place after WIDTH shifts
  if (WIDTH == 1) begin : g_res1
    assign res_shift = fs;
  end else begin : g_resn
    assign res_shift = {fs, res[WIDTH-1:1]};
  end

  assign accept    = in_valid && (state == IDLE);
  assign last      = (cnt == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = res;
  assign cout      = carry;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      sa    <= a;
      sb    <= bload;
      carry <= cload;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= res_shift;
      carry <= fc;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule
